// File: rtl/piso_serializer_pkg.sv
// Shared defaults and state encoding for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

  localparam int unsigned PKG_DATA_WIDTH = 16;
  localparam int unsigned PKG_NUM_REGS   = 8;
  localparam int unsigned PKG_IDX_W      = $clog2(PKG_NUM_REGS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: loads NUM_REGS words in one handshake and
// emits them highest index first over a valid/ready stream.
// Optional feature macro: SER_DOUBLE_BUF_EN (hold buffer for gap-free blocks).
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int unsigned NUM_REGS   = PKG_NUM_REGS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] pDataIn,
  input  logic                           load_valid,
  output logic                           load_ready,
  output logic [DATA_WIDTH-1:0]          serialDataOut,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);
  localparam int unsigned BufW = NUM_REGS * DATA_WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);

  state_e          r_state, w_state_next;
  logic [IdxW-1:0] r_idx, w_idx_next;
  logic [BufW-1:0] r_buf, w_buf_next;

  logic                  w_load;
  logic                  w_xfer;
  logic                  w_last_xfer;
  logic [DATA_WIDTH-1:0] w_word;

`ifdef SER_DOUBLE_BUF_EN
  logic [BufW-1:0] r_hold, w_hold_next;
  logic            r_hold_full, w_hold_full_next;
  assign load_ready = !r_hold_full;
`else
  assign load_ready = (r_state == ST_IDLE);
`endif

  assign out_valid   = (r_state == ST_SHIFT);
  assign busy        = out_valid;
  assign out_last    = out_valid && (r_idx == '0);
  assign w_load      = load_valid && load_ready;
  assign w_xfer      = out_valid && out_ready;
  assign w_last_xfer = w_xfer && (r_idx == '0);

  // Select the word addressed by the index from the registered buffer.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_idx == IdxW'(i)) w_word = r_buf[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output is forced to zero whenever no sample is offered.
  assign serialDataOut = out_valid ? w_word : '0;

  // Next-state logic: load, index countdown and block completion.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_buf_next   = r_buf;
`ifdef SER_DOUBLE_BUF_EN
    w_hold_next      = r_hold;
    w_hold_full_next = r_hold_full;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_buf_next   = pDataIn;
          w_idx_next   = LastIdx;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_xfer) begin
          if (r_idx != '0) begin
            w_idx_next = r_idx - 1'b1;
          end else begin
`ifdef SER_DOUBLE_BUF_EN
            if (r_hold_full) begin
              w_buf_next       = r_hold;
              w_idx_next       = LastIdx;
              w_hold_full_next = 1'b0;
            end else if (w_load) begin
              // Empty hold and a load on the final transfer: bypass the hold.
              w_buf_next = pDataIn;
              w_idx_next = LastIdx;
            end else begin
              w_state_next = ST_IDLE;
            end
`else
            w_state_next = ST_IDLE;
`endif
          end
        end
`ifdef SER_DOUBLE_BUF_EN
        if (w_load && !w_last_xfer) begin
          w_hold_next      = pDataIn;
          w_hold_full_next = 1'b1;
        end
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, index and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_buf   <= w_buf_next;
    end
  end

`ifdef SER_DOUBLE_BUF_EN
  // Holding buffer for the block queued behind the one being shifted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_hold      <= w_hold_next;
      r_hold_full <= w_hold_full_next;
    end
  end
`endif

endmodule
